// File: rtl/instr_mem_param.sv
// instr_mem_param: writable instruction memory with a valid/ready fetch port, a fixed wait-state latency and a program-load port. Ports: clk, rst (async, active-high); req_valid/req_ready/req_addr carry fetch requests; resp_valid/resp_data/resp_err return each response; load_en/load_addr/load_data write one word per cycle. Defining INSTR_MEM_BOUNDS_EN flags misaligned or out-of-range fetches on resp_err; otherwise the fetch index wraps modulo DEPTH.
module instr_mem_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int DEPTH = 32,
  parameter int WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(32'h00000013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data
);
  localparam int OFF = $clog2(DATA_W / 8);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q, rd_addr, rd_word, ld_word;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic accept, go_resp, rd_err;
  assign req_ready = state != WAIT;
  assign resp_valid = state == RESP;
  assign accept = req_valid && req_ready;
  // With no wait states the array is read on the accept edge itself, before addr_q holds the address
  assign go_resp = (WAIT_CYCLES == 0) ? accept : (state == WAIT && cnt == 4'd0);
  assign rd_addr = (WAIT_CYCLES == 0) ? req_addr : addr_q;
  assign rd_word = rd_addr >> OFF;
  assign ld_word = load_addr >> OFF;
`ifdef INSTR_MEM_BOUNDS_EN
  assign rd_err = (rd_addr & OFF_MASK) != '0 || 32'(rd_word) >= DEPTH;
  assign rd_data = rd_err ? INIT_WORD : mem[IW'(rd_word)];
`else
  assign rd_err = 1'b0;
  assign rd_data = mem[IW'(32'(rd_word) % DEPTH)];
`endif
  // Non-blocking write means a same-edge fetch of the loaded word still sees the old contents
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_WORD;
    else if (load_en && 32'(ld_word) < DEPTH)
      mem[IW'(ld_word)] <= load_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      addr_q <= '0;
      resp_data <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) addr_q <= req_addr;
      if (go_resp) begin
        resp_data <= rd_data;
        resp_err <= rd_err;
      end
      if (accept) begin
        state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt <= 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
      end else if (state == WAIT) begin
        state <= (cnt == 4'd0) ? RESP : WAIT;
        cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
      end else
        state <= IDLE;
    end
endmodule

// File: tb/tb_instr_mem_param.sv
// tb_instr_mem_param: directed bench for instr_mem_param, one zero-wait instance and one 3-wait-state instance with an 8-bit address.
module tb_instr_mem_param;
  logic clk = 1'b0, rst = 1'b1;
  logic v0 = 1'b0, le0 = 1'b0;
  logic [6:0] a0 = '0, la0 = '0;
  logic [31:0] ld0 = '0;
  logic r0, rv0, re0;
  logic [31:0] rd0;
  logic v3 = 1'b0, le3 = 1'b0;
  logic [7:0] a3 = '0, la3 = '0;
  logic [31:0] ld3 = '0;
  logic r3, rv3, re3;
  logic [31:0] rd3;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  instr_mem_param dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(r0), .req_addr(a0),
    .resp_valid(rv0), .resp_data(rd0), .resp_err(re0),
    .load_en(le0), .load_addr(la0), .load_data(ld0)
  );
  instr_mem_param #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_ready(r3), .req_addr(a3),
    .resp_valid(rv3), .resp_data(rd3), .resp_err(re3),
    .load_en(le3), .load_addr(la3), .load_data(ld3)
  );
  typedef struct {
    logic le;
    logic [6:0] la;
    logic [31:0] ld;
    logic rv;
    logic [6:0] ra;
    logic ev;
    logic [31:0] ed;
  } vec_t;
  vec_t tv [12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic load3(input logic [7:0] a, input logic [31:0] d);
    le3 = 1'b1; la3 = a; ld3 = d;
    @(posedge clk); #1;
    le3 = 1'b0;
  endtask
  task automatic fetch3(input logic [7:0] a, input logic [31:0] ed, input logic ee, input string nm);
    v3 = 1'b1; a3 = a;
    @(posedge clk); #1;
    v3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk({nm, " ready_low"}, 32'(r3), 32'd0);
      chk({nm, " no_early_valid"}, 32'(rv3), 32'd0);
      @(posedge clk); #1;
    end
    chk({nm, " valid"}, 32'(rv3), 32'd1);
    chk({nm, " ready_back"}, 32'(r3), 32'd1);
    chk({nm, " data"}, rd3, ed);
    chk({nm, " err"}, 32'(re3), 32'(ee));
    @(posedge clk); #1;
    chk({nm, " valid_drop"}, 32'(rv3), 32'd0);
    chk({nm, " data_hold"}, rd3, ed);
  endtask
  initial begin
    tv[0]  = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h00, 1'b1, 32'h00000013};
    tv[1]  = '{1'b0, 7'h00, 32'h0,        1'b0, 7'h00, 1'b0, 32'h00000013};
    tv[2]  = '{1'b1, 7'h00, 32'h00700813, 1'b0, 7'h00, 1'b0, 32'h00000013};
    tv[3]  = '{1'b1, 7'h04, 32'h00002217, 1'b0, 7'h00, 1'b0, 32'h00000013};
    tv[4]  = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h00, 1'b1, 32'h00700813};
    tv[5]  = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h04, 1'b1, 32'h00002217};
    tv[6]  = '{1'b1, 7'h04, 32'hDEADBEEF, 1'b1, 7'h04, 1'b1, 32'h00002217};
    tv[7]  = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h04, 1'b1, 32'hDEADBEEF};
    tv[8]  = '{1'b1, 7'h7C, 32'h12345678, 1'b0, 7'h00, 1'b0, 32'hDEADBEEF};
    tv[9]  = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h7C, 1'b1, 32'h12345678};
    tv[10] = '{1'b0, 7'h00, 32'h0,        1'b0, 7'h00, 1'b0, 32'h12345678};
    tv[11] = '{1'b0, 7'h00, 32'h0,        1'b1, 7'h08, 1'b1, 32'h00000013};
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready0", 32'(r0), 32'd1);
    chk("rst valid0", 32'(rv0), 32'd0);
    chk("rst data0", rd0, 32'd0);
    chk("rst err0", 32'(re0), 32'd0);
    chk("rst ready3", 32'(r3), 32'd1);
    chk("rst valid3", 32'(rv3), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      le0 = tv[i].le; la0 = tv[i].la; ld0 = tv[i].ld;
      v0 = tv[i].rv; a0 = tv[i].ra;
      @(posedge clk); #1;
      chk($sformatf("vec%0d valid", i), 32'(rv0), 32'(tv[i].ev));
      chk($sformatf("vec%0d data", i), rd0, tv[i].ed);
      chk($sformatf("vec%0d ready", i), 32'(r0), 32'd1);
      chk($sformatf("vec%0d err", i), 32'(re0), 32'd0);
    end
    le0 = 1'b0; v0 = 1'b0;
    load3(8'h04, 32'h00002217);
    fetch3(8'h04, 32'h00002217, 1'b0, "wait3 fetch");
`ifdef INSTR_MEM_BOUNDS_EN
    fetch3(8'h02, 32'h00000013, 1'b1, "misaligned");
    fetch3(8'h80, 32'h00000013, 1'b1, "out_of_range");
    fetch3(8'h04, 32'h00002217, 1'b0, "good_after_err");
`else
    load3(8'h00, 32'h11111111);
    load3(8'h80, 32'hAAAAAAAA);
    fetch3(8'h82, 32'h11111111, 1'b0, "wrap");
    fetch3(8'h06, 32'h00002217, 1'b0, "offset_ignored");
`endif
    v3 = 1'b1; a3 = 8'h04;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst ready", 32'(r3), 32'd1);
    chk("midrst valid", 32'(rv3), 32'd0);
    chk("midrst data", rd3, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("midrst no_resp%0d", k), 32'(rv3), 32'd0);
      @(posedge clk); #1;
    end
    fetch3(8'h04, 32'h00000013, 1'b0, "reinit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
